// File: rtl/rlbp_rdout_pkg.sv
// ============================================================================
// Module   : rlbp_rdout_pkg
// Brief    : Shared constants and types for the RLBP readout FIFO slice.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rlbp_rdout_pkg;

  // Width of one packed FIFO word.
  localparam int WORD_W             = 32;
  // Default code geometry; CODE_W * CODES_PER_WORD must equal WORD_W.
  localparam int DEF_CODE_W         = 8;
  localparam int DEF_CODES_PER_WORD = 4;
  localparam int LANE_W             = $clog2(DEF_CODES_PER_WORD);

  // Index of the byte lane a completed code is written into.
  typedef logic [LANE_W-1:0] lane_t;

endpackage

`default_nettype wire

// File: rtl/rlbp_readout_fifo_if.sv
// ============================================================================
// Module   : rlbp_readout_fifo_if
// Brief    : Serial input, pop handshake and status bundle of the readout FIFO.
//            master = producer/consumer side, slave = the FIFO itself.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rlbp_readout_fifo_if
  import rlbp_rdout_pkg::*;
#(
  parameter int DEPTH = 16
);
  logic                    ser_valid;
  logic                    ser_data;
  logic                    ser_sof;
  logic                    flush;
  logic                    rd_en;
  logic                    clr_ovf;
  logic [WORD_W-1:0]       rd_data;
  logic                    rd_valid;
  logic                    empty;
  logic                    full;
  logic [$clog2(DEPTH):0]  level;
  logic                    overflow;
  logic                    irq;

  modport master (
    output ser_valid, ser_data, ser_sof, flush, rd_en, clr_ovf,
    input  rd_data, rd_valid, empty, full, level, overflow, irq
  );

  modport slave (
    input  ser_valid, ser_data, ser_sof, flush, rd_en, clr_ovf,
    output rd_data, rd_valid, empty, full, level, overflow, irq
  );
endinterface

`default_nettype wire

// File: rtl/rlbp_s2p.sv
// ============================================================================
// Module   : rlbp_s2p
// Brief    : MSB-first serial-to-parallel deserialiser for RLBP codes. A set
//            sof bit restarts the code; code/code_valid are presented in the
//            same cycle as the final bit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rlbp_s2p
  import rlbp_rdout_pkg::*;
#(
  parameter int CODE_W = DEF_CODE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              ser_valid,
  input  logic              ser_data,
  input  logic              ser_sof,
  output logic [CODE_W-1:0] code,
  output logic              code_valid
);
  localparam int CNT_W = $clog2(CODE_W + 1);

  logic [CODE_W-1:0] r_shift;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [CNT_W-1:0]  w_cnt_next;
  logic              w_done;

  // Bit count after this bit: sof restarts the code at its MSB.
  always_comb begin
    w_cnt_next = ser_sof ? CNT_W'(1) : r_bit_cnt + CNT_W'(1);
    w_done     = ser_valid && (w_cnt_next == CNT_W'(CODE_W));
  end

  // The shift register already includes the incoming bit at the output.
  assign code       = {r_shift[CODE_W-2:0], ser_data};
  assign code_valid = w_done;

  // Shift in one bit per strobe; a completed code returns the count to zero.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else if (ser_valid) begin
      r_shift   <= code;
      r_bit_cnt <= w_done ? '0 : w_cnt_next;
    end
  end

endmodule

`default_nettype wire

// File: rtl/rlbp_readout_fifo.sv
// ============================================================================
// Module   : rlbp_readout_fifo
// Brief    : Deserialises the RLBP code stream, packs CODES_PER_WORD codes per
//            32-bit word and buffers the words in a synchronous FIFO.
//            Optional level interrupt enabled by defining RLBP_RDOUT_IRQ_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rlbp_readout_fifo
  import rlbp_rdout_pkg::*;
#(
  parameter int CODE_W         = DEF_CODE_W,
  parameter int CODES_PER_WORD = DEF_CODES_PER_WORD,
  parameter int DEPTH          = 16,
  parameter int IRQ_LEVEL      = 8
) (
  input  logic                clk,
  input  logic                rst,
  rlbp_readout_fifo_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [CODE_W-1:0]  w_code;
  logic               w_code_valid;
  lane_t              r_lane;
  logic               w_last_lane;
  logic [WORD_W-1:0]  r_word_buf;
  logic [WORD_W-1:0]  w_word_next;
  logic               w_push;
  logic               w_accept;
  logic               w_drop;
  logic               w_pop;
  logic [PW-1:0]      r_wr_ptr;
  logic [PW-1:0]      r_rd_ptr;
  logic [WORD_W-1:0]  r_mem [DEPTH];
  logic [WORD_W-1:0]  r_rd_data;
  logic               r_rd_valid;
  logic               r_ovf;
  logic               w_empty;
  logic               w_full;
  logic [PW-1:0]      w_level;

  rlbp_s2p #(
    .CODE_W (CODE_W)
  ) u_s2p (
    .clk        (clk),
    .rst        (rst),
    .flush      (bus.flush),
    .ser_valid  (bus.ser_valid),
    .ser_data   (bus.ser_data),
    .ser_sof    (bus.ser_sof),
    .code       (w_code),
    .code_valid (w_code_valid)
  );

  // Merge the completed code into its lane so a full word can be pushed in
  // the same cycle as the last code completes.
  for (genvar gi = 0; gi < CODES_PER_WORD; gi++) begin : g_lane
    assign w_word_next[gi*CODE_W +: CODE_W] =
      (w_code_valid && (r_lane == lane_t'(gi))) ? w_code
                                                : r_word_buf[gi*CODE_W +: CODE_W];
  end

  assign w_last_lane = (r_lane == lane_t'(CODES_PER_WORD - 1));
  assign w_push      = w_code_valid && w_last_lane && !bus.flush;

  // Status decode from pointers carrying an extra wrap bit.
  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_level  = r_wr_ptr - r_rd_ptr;

  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign w_pop    = bus.rd_en && !w_empty && !bus.flush;
  assign w_accept = w_push && (!w_full || bus.rd_en);
  assign w_drop   = w_push && !w_accept;

  // Packer: track the lane and hold partially filled words.
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      r_lane     <= '0;
      r_word_buf <= '0;
    end else if (w_code_valid) begin
      r_word_buf <= w_word_next;
      r_lane     <= w_last_lane ? '0 : r_lane + lane_t'(1);
    end
  end

  // Storage array write; contents are qualified by the pointers so no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mem[r_wr_ptr[AW-1:0]] <= w_word_next;
    end
  end

  // Read/write pointer advance.
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_accept) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)    r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  // Registered read port: head word and one-cycle valid strobe.
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_pop;
      if (w_pop) r_rd_data <= r_mem[r_rd_ptr[AW-1:0]];
    end
  end

  // Sticky overflow; a new drop wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst)             r_ovf <= 1'b0;
    else if (w_drop)     r_ovf <= 1'b1;
    else if (bus.clr_ovf) r_ovf <= 1'b0;
  end

  assign bus.rd_data  = r_rd_data;
  assign bus.rd_valid = r_rd_valid;
  assign bus.empty    = w_empty;
  assign bus.full     = w_full;
  assign bus.level    = w_level;
  assign bus.overflow = r_ovf;

`ifdef RLBP_RDOUT_IRQ_EN
  logic r_irq;

  // Level interrupt, registered from the current fill level.
  always_ff @(posedge clk) begin
    if (rst) r_irq <= 1'b0;
    else     r_irq <= (w_level >= PW'(IRQ_LEVEL));
  end

  assign bus.irq = r_irq;
`else
  logic w_unused_irq_level;

  assign w_unused_irq_level = (IRQ_LEVEL != 0);
  assign bus.irq            = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rlbp_readout_fifo.sv
// ============================================================================
// Module   : tb_rlbp_readout_fifo
// Brief    : Self-checking bench for rlbp_readout_fifo with a queue-based
//            reference model. Honours RLBP_RDOUT_IRQ_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rlbp_readout_fifo;
  localparam int DEPTH     = 16;
  localparam int IRQ_LEVEL = 8;
  localparam int CODE_W    = 8;
`ifdef RLBP_RDOUT_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic clk;
  logic rst;

  rlbp_readout_fifo_if #(.DEPTH(DEPTH)) bus ();

  rlbp_readout_fifo #(
    .CODE_W         (CODE_W),
    .CODES_PER_WORD (4),
    .DEPTH          (DEPTH),
    .IRQ_LEVEL      (IRQ_LEVEL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [31:0] q[$];
  int          m_code;
  int          m_n;
  int          m_lane;
  logic [31:0] m_word;
  bit          m_ovf;
  bit          m_rdv;
  logic [31:0] m_rdd;
  bit          m_irq;

  // Model one clock edge from the inputs that were applied before it.
  function automatic void model_step(bit v, bit d, bit sof, bit rd, bit fl, bit clr);
    int lvl_before = q.size();
    bit push = 0;
    bit drop = 0;
    if (rst) begin
      q.delete(); m_code = 0; m_n = 0; m_lane = 0; m_word = '0;
      m_ovf = 0; m_rdv = 0; m_rdd = '0; m_irq = 0;
      return;
    end
    m_irq = IRQ_ON && (lvl_before >= IRQ_LEVEL);
    if (fl) begin
      q.delete(); m_code = 0; m_n = 0; m_lane = 0; m_word = '0;
      m_rdv = 0; m_rdd = '0;
      if (clr) m_ovf = 0;
      return;
    end
    if (v) begin
      m_code = sof ? int'(d) : (((m_code << 1) | int'(d)) & 8'hFF);
      m_n    = sof ? 1 : m_n + 1;
      if (m_n == CODE_W) begin
        m_n = 0;
        m_word[m_lane*8 +: 8] = m_code[7:0];
        m_lane++;
        if (m_lane == 4) begin
          m_lane = 0;
          push = 1;
        end
      end
    end
    if (rd && q.size() > 0) begin
      m_rdd = q.pop_front();
      m_rdv = 1;
    end else begin
      m_rdv = 0;
    end
    if (push) begin
      if (q.size() < DEPTH) q.push_back(m_word);
      else drop = 1;
    end
    if (drop) m_ovf = 1;
    else if (clr) m_ovf = 0;
  endfunction

  // Apply one cycle of inputs, advance the model at the edge, sample at +1.
  task automatic cycle(input bit v, input bit d, input bit sof,
                       input bit rd, input bit fl, input bit clr);
    bus.ser_valid = v;
    bus.ser_data  = d;
    bus.ser_sof   = sof;
    bus.rd_en     = rd;
    bus.flush     = fl;
    bus.clr_ovf   = clr;
    @(posedge clk);
    model_step(v, d, sof, rd, fl, clr);
    #1;
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0);
  endtask

  // Send one code MSB first; optional sof on the MSB and rd_en on the last bit.
  task automatic send_code(input logic [7:0] c, input bit sof_first, input bit rd_last);
    for (int i = 7; i >= 0; i--)
      cycle(1, c[i], sof_first && (i == 7), rd_last && (i == 0), 0, 0);
  endtask

  // Send four random codes; returns the packed word they should form.
  task automatic send_word(input bit rd_last, output logic [31:0] w);
    logic [7:0] c;
    for (int k = 0; k < 4; k++) begin
      c = 8'($urandom_range(0, 255));
      w[k*8 +: 8] = c;
      send_code(c, 1'b1, rd_last && (k == 3));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    idle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (bus.rd_data !== 32'h0) begin n_err++; $display("FAIL reset_rd_data: got %h expected 0", bus.rd_data); end
    n_cmp++; if (bus.rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_rd_valid: got %b expected 0", bus.rd_valid); end
    n_cmp++; if (bus.empty !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b expected 1", bus.empty); end
    n_cmp++; if (bus.full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b expected 0", bus.full); end
    n_cmp++; if (bus.level !== 5'd0) begin n_err++; $display("FAIL reset_level: got %0d expected 0", bus.level); end
    n_cmp++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b expected 0", bus.overflow); end
    n_cmp++; if (bus.irq !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b expected 0", bus.irq); end
  endtask

  task automatic test_pack_basic();
    send_code(8'hA5, 1, 0);
    send_code(8'h3C, 1, 0);
    send_code(8'hFF, 1, 0);
    n_cmp++; if (bus.level !== 5'd0) begin n_err++; $display("FAIL t1_level_before: got %0d expected 0", bus.level); end
    send_code(8'h01, 1, 0);
    n_cmp++; if (bus.level !== 5'd1) begin n_err++; $display("FAIL t1_level_after: got %0d expected 1", bus.level); end
    cycle(0, 0, 0, 1, 0, 0);
    n_cmp++; if (bus.rd_valid !== 1'b1) begin n_err++; $display("FAIL t1_rd_valid: got %b expected 1", bus.rd_valid); end
    n_cmp++; if (bus.rd_data !== 32'h01FF3CA5) begin n_err++; $display("FAIL t1_rd_data: got %h expected 01ff3ca5", bus.rd_data); end
    idle();
    n_cmp++; if (bus.rd_valid !== 1'b0) begin n_err++; $display("FAIL t1_strobe_once: got %b expected 0", bus.rd_valid); end
    n_cmp++; if (bus.rd_data !== 32'h01FF3CA5) begin n_err++; $display("FAIL t1_rd_hold: got %h expected 01ff3ca5", bus.rd_data); end
    n_cmp++; if (bus.empty !== 1'b1) begin n_err++; $display("FAIL t1_empty: got %b expected 1", bus.empty); end
  endtask

  task automatic test_sof_resync();
    logic [7:0] junk;
    junk = 8'hF8;
    for (int i = 7; i >= 3; i--) cycle(1, junk[i], i == 7, 0, 0, 0);
    send_code(8'h7E, 1, 0);
    send_code(8'h11, 0, 0);
    send_code(8'h22, 0, 0);
    send_code(8'h33, 0, 0);
    cycle(0, 0, 0, 1, 0, 0);
    n_cmp++; if (bus.rd_data !== 32'h3322117E) begin n_err++; $display("FAIL t2_resync_word: got %h expected 3322117e", bus.rd_data); end
    idle();
  endtask

  task automatic test_overflow();
    logic [31:0] w;
    for (int k = 0; k < DEPTH; k++) send_word(0, w);
    n_cmp++; if (bus.full !== 1'b1) begin n_err++; $display("FAIL t3_full: got %b expected 1", bus.full); end
    n_cmp++; if (bus.level !== 5'(DEPTH)) begin n_err++; $display("FAIL t3_level16: got %0d expected %0d", bus.level, DEPTH); end
    n_cmp++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL t3_ovf_early: got %b expected 0", bus.overflow); end
    send_word(0, w);
    n_cmp++; if (bus.overflow !== 1'b1) begin n_err++; $display("FAIL t3_ovf_set: got %b expected 1", bus.overflow); end
    n_cmp++; if (bus.level !== 5'(DEPTH)) begin n_err++; $display("FAIL t3_level_kept: got %0d expected %0d", bus.level, DEPTH); end
    cycle(0, 0, 0, 0, 1, 0);
    n_cmp++; if (bus.overflow !== 1'b1) begin n_err++; $display("FAIL t5_flush_keeps_ovf: got %b expected 1", bus.overflow); end
    n_cmp++; if (bus.level !== 5'd0 || bus.empty !== 1'b1) begin n_err++; $display("FAIL t5_flush_level: got %0d/%b expected 0/1", bus.level, bus.empty); end
    cycle(0, 0, 0, 0, 0, 1);
    n_cmp++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL t3_clr_ovf: got %b expected 0", bus.overflow); end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] sent[$];
    logic [31:0] w;
    for (int k = 0; k < DEPTH; k++) begin
      send_word(0, w);
      sent.push_back(w);
    end
    send_word(1, w);
    sent.push_back(w);
    n_cmp++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL t4_no_ovf: got %b expected 0", bus.overflow); end
    n_cmp++; if (bus.level !== 5'(DEPTH)) begin n_err++; $display("FAIL t4_level: got %0d expected %0d", bus.level, DEPTH); end
    w = sent.pop_front();
    n_cmp++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== w) begin n_err++; $display("FAIL t4_oldest: got %b/%h expected 1/%h", bus.rd_valid, bus.rd_data, w); end
    for (int k = 0; k < DEPTH; k++) begin
      cycle(0, 0, 0, 1, 0, 0);
      w = sent.pop_front();
      n_cmp++; if (bus.rd_data !== w) begin n_err++; $display("FAIL t4_drain[%0d]: got %h expected %h", k, bus.rd_data, w); end
    end
    idle();
    n_cmp++; if (bus.empty !== 1'b1) begin n_err++; $display("FAIL t4_empty: got %b expected 1", bus.empty); end
  endtask

  task automatic test_flush();
    logic [31:0] w;
    send_word(0, w);
    send_word(0, w);
    send_code(8'h99, 1, 0);
    for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 1, 0);
    n_cmp++; if (bus.level !== 5'd0 || bus.empty !== 1'b1) begin n_err++; $display("FAIL t5_level: got %0d/%b expected 0/1", bus.level, bus.empty); end
    send_code(8'h5A, 0, 0);
    send_code(8'h12, 0, 0);
    send_code(8'h34, 0, 0);
    send_code(8'h56, 0, 0);
    cycle(0, 0, 0, 1, 0, 0);
    n_cmp++; if (bus.rd_data !== 32'h5634125A) begin n_err++; $display("FAIL t5_lane0: got %h expected 5634125a", bus.rd_data); end
    idle();
  endtask

  task automatic test_irq();
    logic [31:0] w;
    for (int k = 0; k < IRQ_LEVEL; k++) send_word(0, w);
    n_cmp++; if (bus.irq !== 1'b0) begin n_err++; $display("FAIL t6_irq_delay: got %b expected 0", bus.irq); end
    idle();
    n_cmp++; if (bus.irq !== IRQ_ON) begin n_err++; $display("FAIL t6_irq_set: got %b expected %b", bus.irq, IRQ_ON); end
    cycle(0, 0, 0, 1, 0, 0);
    n_cmp++; if (bus.level !== 5'(IRQ_LEVEL - 1)) begin n_err++; $display("FAIL t6_level: got %0d expected %0d", bus.level, IRQ_LEVEL - 1); end
    idle();
    n_cmp++; if (bus.irq !== 1'b0) begin n_err++; $display("FAIL t6_irq_clear: got %b expected 0", bus.irq); end
    cycle(0, 0, 0, 0, 1, 0);
    idle();
  endtask

  // Randomised traffic against the model, every output checked every cycle.
  task automatic test_random();
    bit v, d, sof, rd, fl, clr;
    do_reset();
    for (int t = 0; t < 1200; t++) begin
      v   = ($urandom_range(0, 99) < ((t < 800) ? 95 : 70));
      d   = 1'($urandom_range(0, 1));
      sof = ($urandom_range(0, 39) == 0);
      rd  = ($urandom_range(0, 99) < ((t < 800) ? 1 : 50));
      fl  = ($urandom_range(0, 299) == 0);
      clr = ($urandom_range(0, 59) == 0);
      cycle(v, d, sof, rd, fl, clr);
      n_cmp++; if (bus.level !== 5'(q.size())) begin n_err++; $display("FAIL rnd_level@%0d: got %0d expected %0d", t, bus.level, q.size()); end
      n_cmp++; if (bus.empty !== (q.size() == 0)) begin n_err++; $display("FAIL rnd_empty@%0d: got %b expected %b", t, bus.empty, q.size() == 0); end
      n_cmp++; if (bus.full !== (q.size() == DEPTH)) begin n_err++; $display("FAIL rnd_full@%0d: got %b expected %b", t, bus.full, q.size() == DEPTH); end
      n_cmp++; if (bus.overflow !== m_ovf) begin n_err++; $display("FAIL rnd_ovf@%0d: got %b expected %b", t, bus.overflow, m_ovf); end
      n_cmp++; if (bus.rd_valid !== m_rdv) begin n_err++; $display("FAIL rnd_rd_valid@%0d: got %b expected %b", t, bus.rd_valid, m_rdv); end
      n_cmp++; if (bus.rd_data !== m_rdd) begin n_err++; $display("FAIL rnd_rd_data@%0d: got %h expected %h", t, bus.rd_data, m_rdd); end
      n_cmp++; if (bus.irq !== m_irq) begin n_err++; $display("FAIL rnd_irq@%0d: got %b expected %b", t, bus.irq, m_irq); end
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.ser_valid = 1'b0;
    bus.ser_data  = 1'b0;
    bus.ser_sof   = 1'b0;
    bus.rd_en     = 1'b0;
    bus.flush     = 1'b0;
    bus.clr_ovf   = 1'b0;
    test_reset();
    test_pack_basic();
    test_sof_resync();
    test_overflow();
    test_full_push_pop();
    test_flush();
    test_irq();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
